typedef_rr_sched: RTL and testbench



---
 rtl/typedef_rr_sched.sv | 131 +++++++++++++
 tb/tb_typedef_rr_sched.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/typedef_rr_sched.sv
// Round-robin grant scheduler sharing one resource among NREQ requesters.
// Typedefs live at compilation-unit, module and generate-block scope.

typedef enum logic [1:0] {
  IDLE  = 2'd0,
  GRANT = 2'd1,
  COOL  = 2'd2
} rr_state_e;

module typedef_rr_sched #(
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         done,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] gnt_idx,
  output logic                    busy,
  output logic [1:0]              state_o,
  output logic                    timeout
);
  localparam int IW = $clog2(NREQ);
  localparam int HW = $clog2(MAX_HOLD);

  typedef logic [IW-1:0] idx_t;

  rr_state_e     state_r;
  idx_t          last_r;
  idx_t          pick_s;
  logic          any_req_s;
  logic [HW-1:0] hold_r;

  // The scan mask carries the requests plus an any-request flag in its top bit,
  // hence the wider local idx_t that shadows the module-scope one.
  if (1'b1) begin : g_search
    typedef logic [NREQ:0] idx_t;
    idx_t scan_mask_s;

    // Priority search from (last+1) upward; the highest k is visited first so
    // the nearest requester after the pointer wins.
    always_comb begin
      logic [IW-1:0] cidx;
      scan_mask_s = {|req, req};
      pick_s      = '0;
      cidx        = '0;
      for (int k = NREQ; k >= 1; k--) begin
        cidx = last_r + IW'(k);
        if (scan_mask_s[{1'b0, cidx}]) begin
          pick_s = cidx;
        end else begin
          pick_s = pick_s;
        end
      end
    end

    assign any_req_s = scan_mask_s[NREQ];
  end

  localparam idx_t LAST_RST = idx_t'(NREQ - 1);

  assign state_o = state_r;

  // Scheduler FSM; all outputs registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      gnt     <= '0;
      gnt_idx <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
      hold_r  <= '0;
      last_r  <= LAST_RST;
    end else begin
      case (state_r)
        IDLE: begin
          timeout <= 1'b0;
          if (any_req_s) begin
            state_r <= GRANT;
            gnt     <= NREQ'(1) << pick_s;
            gnt_idx <= pick_s;
            busy    <= 1'b1;
            hold_r  <= '0;
          end
        end
        GRANT: begin
          // done beats timeout when both hold in the same cycle
          if (done[gnt_idx] || !req[gnt_idx]) begin
            state_r <= COOL;
            gnt     <= '0;
            busy    <= 1'b0;
            last_r  <= gnt_idx;
            hold_r  <= '0;
            timeout <= 1'b0;
          end else if (hold_r == HW'(MAX_HOLD - 1)) begin
            state_r <= COOL;
            gnt     <= '0;
            busy    <= 1'b0;
            last_r  <= gnt_idx;
            hold_r  <= '0;
            timeout <= 1'b1;
          end else begin
            hold_r  <= hold_r + HW'(1);
            timeout <= 1'b0;
          end
        end
        COOL: begin
          state_r <= IDLE;
          timeout <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          gnt     <= '0;
          busy    <= 1'b0;
          timeout <= 1'b0;
          hold_r  <= '0;
        end
      endcase
    end
  end

  // Output invariants: grant never multi-hot, and present exactly while in GRANT.
  always @(posedge clk) begin
    if (!rst) begin
      gnt_onehot: assert ($onehot0(gnt));
      gnt_state:  assert ((gnt != '0) == (state_o == 2'd1));
    end
  end

endmodule

// File: tb/tb_typedef_rr_sched.sv
// Self-checking bench for typedef_rr_sched: directed scenarios plus random
// stimulus compared against a behavioural round-robin model.

module tb_typedef_rr_sched;
  localparam int NREQ     = 4;
  localparam int MAX_HOLD = 8;

  logic            clk;
  logic            rst;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] done;
  logic [NREQ-1:0] gnt;
  logic [1:0]      gnt_idx;
  logic            busy;
  logic [1:0]      state_o;
  logic            timeout;

  int checks;
  int errors;

  // behavioural model: 0 idle, 1 granted, 2 cooling
  int m_state;
  int m_idx;
  int m_last;
  int m_hold;
  bit m_timeout;

  typedef_rr_sched #(.NREQ(NREQ), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done), .gnt(gnt),
    .gnt_idx(gnt_idx), .busy(busy), .state_o(state_o), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit bit_of(input logic [NREQ-1:0] v, input int i);
    return ((v >> i) & 4'd1) != 4'd0;
  endfunction

  task automatic model_step();
    bit found;
    int i;
    if (rst) begin
      m_state = 0; m_idx = 0; m_last = NREQ - 1; m_hold = 0; m_timeout = 0;
    end else if (m_state == 0) begin
      m_timeout = 0;
      found = 0;
      for (int k = 1; k <= NREQ; k++) begin
        i = (m_last + k) % NREQ;
        if (!found && bit_of(req, i)) begin
          found = 1; m_idx = i; m_state = 1; m_hold = 0;
        end
      end
    end else if (m_state == 1) begin
      if (bit_of(done, m_idx) || !bit_of(req, m_idx)) begin
        m_state = 2; m_last = m_idx; m_hold = 0; m_timeout = 0;
      end else if (m_hold == MAX_HOLD - 1) begin
        m_state = 2; m_last = m_idx; m_hold = 0; m_timeout = 1;
      end else begin
        m_hold = m_hold + 1;
      end
    end else begin
      m_state = 0; m_timeout = 0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b0000; done = 4'b0000;
    tick(); tick();
    checks++;
    if (gnt !== 4'b0000 || gnt_idx !== 2'd0 || busy !== 1'b0 ||
        state_o !== 2'd0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset: gnt=%b idx=%0d busy=%b state=%0d to=%b, want 0000 0 0 0 0",
               gnt, gnt_idx, busy, state_o, timeout);
    end
    rst = 1'b0;
  endtask

  task automatic test_timeout();
    req = 4'b0101;
    tick();
    checks++;
    if (gnt !== 4'b0001 || busy !== 1'b1 || state_o !== 2'd1) begin
      errors++;
      $display("FAIL first_grant: gnt=%b busy=%b state=%0d, want 0001 1 1", gnt, busy, state_o);
    end
    for (int c = 0; c < 7; c++) tick();
    checks++;
    if (gnt !== 4'b0001 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL hold_8th: gnt=%b to=%b, want 0001 0", gnt, timeout);
    end
    tick();
    checks++;
    if (gnt !== 4'b0000 || timeout !== 1'b1 || state_o !== 2'd2 || gnt_idx !== 2'd0) begin
      errors++;
      $display("FAIL timeout_pulse: gnt=%b to=%b state=%0d idx=%0d, want 0000 1 2 0",
               gnt, timeout, state_o, gnt_idx);
    end
    tick();
    checks++;
    if (timeout !== 1'b0 || state_o !== 2'd0) begin
      errors++;
      $display("FAIL timeout_single: to=%b state=%0d, want 0 0", timeout, state_o);
    end
    tick();
    checks++;
    if (gnt !== 4'b0100 || gnt_idx !== 2'd2) begin
      errors++;
      $display("FAIL after_timeout: gnt=%b idx=%0d, want 0100 2", gnt, gnt_idx);
    end
    req = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] want;
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      want = 4'b0001 << (n % NREQ);
      tick();
      checks++;
      if (gnt !== want || timeout !== 1'b0) begin
        errors++;
        $display("FAIL rr_grant%0d: gnt=%b to=%b, want %b 0", n, gnt, timeout, want);
      end
      tick();
      done = want;
      tick();
      done = 4'b0000;
      checks++;
      if (gnt !== 4'b0000 || state_o !== 2'd2 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL rr_cool%0d: gnt=%b state=%0d to=%b, want 0000 2 0", n, gnt, state_o, timeout);
      end
      tick();
      checks++;
      if (gnt !== 4'b0000 || state_o !== 2'd0) begin
        errors++;
        $display("FAIL rr_idle%0d: gnt=%b state=%0d, want 0000 0", n, gnt, state_o);
      end
    end
  endtask

  task automatic test_wrap();
    req = 4'b1000;
    tick();
    checks++;
    if (gnt !== 4'b1000 || gnt_idx !== 2'd3) begin
      errors++;
      $display("FAIL wrap_pre: gnt=%b idx=%0d, want 1000 3", gnt, gnt_idx);
    end
    req = 4'b0000;
    tick();
    req = 4'b0011;
    tick(); tick();
    checks++;
    if (gnt !== 4'b0001 || gnt_idx !== 2'd0) begin
      errors++;
      $display("FAIL wrap: gnt=%b idx=%0d, want 0001 0", gnt, gnt_idx);
    end
    req = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_ignored_done();
    req = 4'b0010;
    tick();
    done = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (gnt !== 4'b0010 || busy !== 1'b1 || state_o !== 2'd1) begin
        errors++;
        $display("FAIL ignored_done%0d: gnt=%b busy=%b state=%0d, want 0010 1 1",
                 c, gnt, busy, state_o);
      end
    end
    done = 4'b0000; req = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_withdraw();
    req = 4'b0001;
    tick();
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL withdraw_pre: gnt=%b, want 0001", gnt);
    end
    tick(); tick();
    req = 4'b1100;
    tick();
    checks++;
    if (gnt !== 4'b0000 || state_o !== 2'd2 || timeout !== 1'b0 || gnt_idx !== 2'd0) begin
      errors++;
      $display("FAIL withdraw: gnt=%b state=%0d to=%b idx=%0d, want 0000 2 0 0",
               gnt, state_o, timeout, gnt_idx);
    end
    tick(); tick();
    checks++;
    if (gnt !== 4'b0100 || gnt_idx !== 2'd2) begin
      errors++;
      $display("FAIL withdraw_next: gnt=%b idx=%0d, want 0100 2", gnt, gnt_idx);
    end
  endtask

  task automatic test_reset_mid_grant();
    checks++;
    if (gnt !== 4'b0100 || state_o !== 2'd1) begin
      errors++;
      $display("FAIL midrst_pre: gnt=%b state=%0d, want 0100 1", gnt, state_o);
    end
    req = 4'b1111; rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (gnt !== 4'b0000 || state_o !== 2'd0 || gnt_idx !== 2'd0 ||
        timeout !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst: gnt=%b state=%0d idx=%0d to=%b busy=%b, want 0000 0 0 0 0",
               gnt, state_o, gnt_idx, timeout, busy);
    end
    tick();
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL midrst_after: gnt=%b, want 0001", gnt);
    end
    req = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_random();
    logic [NREQ-1:0] exp_gnt;
    int n_timeouts;
    n_timeouts = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) req = 4'($urandom_range(0, 15));
      done = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      rst  = ($urandom_range(0, 299) == 0);
      tick();
      exp_gnt = (m_state == 1) ? (4'b0001 << m_idx) : 4'b0000;
      if (m_timeout) n_timeouts++;
      checks++;
      if (gnt !== exp_gnt || gnt_idx !== 2'(m_idx) || busy !== (m_state == 1) ||
          state_o !== 2'(m_state) || timeout !== m_timeout) begin
        errors++;
        $display("FAIL random@%0d: gnt=%b idx=%0d busy=%b state=%0d to=%b, want %b %0d %b %0d %b",
                 c, gnt, gnt_idx, busy, state_o, timeout,
                 exp_gnt, m_idx, (m_state == 1), m_state, m_timeout);
      end
    end
    rst = 1'b0; req = 4'b0000; done = 4'b0000;
    checks++;
    if (n_timeouts == 0) begin
      errors++;
      $display("FAIL random_timeouts: saw %0d timeout pulses, want at least 1", n_timeouts);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; req = 4'b0000; done = 4'b0000;
    test_reset();
    test_timeout();
    test_round_robin();
    test_wrap();
    test_ignored_done();
    test_withdraw();
    test_reset_mid_grant();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
